// File: rtl/pwm_peripheral.sv
// 16-pin PWM driver fed by the SPI register bank; all pins share one prescaled 8-bit counter.
// Optional macro PWM_SYNC_UPDATE_EN: shadow the duty cycle so it only changes at period boundaries.
module pwm_peripheral #(
  parameter int PRESCALE   = 13,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] r_presc;
  logic [7:0]            r_pwm_cnt;
  logic                  r_first;
  logic [15:0]           r_out;
  logic                  r_period_start;

  logic        w_tick;
  logic        w_wrap;
  logic [7:0]  w_duty;
  logic        w_pwm_sig;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] r_shadow;

  // First post-reset cycle takes the live input so the opening period is not stuck at 0.
  assign w_duty = r_first ? pwm_duty_cycle : r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= 8'h00;
    end else if (r_first || w_wrap) begin
      r_shadow <= pwm_duty_cycle;
    end
  end
`else
  assign w_duty = pwm_duty_cycle;
`endif

  // 0xFF is full-on rather than 255/256, so no one-tick low glitch.
  assign w_pwm_sig = (w_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < w_duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc        <= '0;
      r_pwm_cnt      <= 8'h00;
      r_first        <= 1'b1;
      r_out          <= 16'h0000;
      r_period_start <= 1'b0;
    end else begin
      r_first        <= 1'b0;
      r_presc        <= w_tick ? '0 : r_presc + PRESCALE_W'(1);
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      r_period_start <= r_first || w_wrap;
      r_out          <= w_en_out & (~w_en_pwm | {16{w_pwm_sig}});
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: randomized and directed stimulus against a period-arithmetic model.
module tb_pwm_peripheral;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] out_w;
  logic        ps_w;

  int          passed = 0;
  int          total  = 0;

  int          n;
  logic [7:0]  m_shadow;
  logic [15:0] exp_out;
  logic        exp_ps;

  pwm_peripheral #(.PRESCALE(P), .PRESCALE_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out             (out_w),
    .period_start    (ps_w)
  );

  always #5 clk = ~clk;

  // Model: n counts clock edges since reset release, so counter = floor(n/P) mod 256.
  task automatic step();
    logic [7:0]  cnt;
    logic [7:0]  d;
    logic        sig;
    logic [15:0] eo, ep;
    if (rst) begin
      exp_out  = 16'h0000;
      exp_ps   = 1'b0;
      n        = 0;
      m_shadow = 8'h00;
    end else begin
      cnt = 8'((n / P) % 256);
`ifdef PWM_SYNC_UPDATE_EN
      d = (n == 0) ? duty : m_shadow;
      if (n == 0 || (n % PER) == PER - 1) m_shadow = duty;
`else
      d = duty;
`endif
      sig     = (d == 8'hFF) ? 1'b1 : (int'(cnt) < int'(d));
      eo      = {en_out_hi, en_out_lo};
      ep      = {en_pwm_hi, en_pwm_lo};
      exp_out = eo & (~ep | {16{sig}});
      exp_ps  = (n == 0) || ((n % PER) == PER - 1);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_out_hi, en_out_lo} = eo;
    {en_pwm_hi, en_pwm_lo} = ep;
  endtask

  task automatic test_reset();
    set_en(16'hFFFF, 16'h0000);
    duty = 8'h80;
    rst  = 1'b1;
    step();
    step();
    total++;
    if (out_w !== 16'h0000 || ps_w !== 1'b0)
      $display("FAIL reset_state: out=%h ps=%b, required out=0000 ps=0", out_w, ps_w);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (ps_w !== 1'b1) $display("FAIL first_period_start: ps=%b, required 1", ps_w);
    else passed++;
    total++;
    if (out_w !== 16'hFFFF) $display("FAIL static_high: out=%h, required ffff", out_w);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if (out_w !== 16'h0000) $display("FAIL reset_mid_run: out=%h, required 0000", out_w);
    else passed++;
    rst = 1'b0;
    step();
    step();
    total++;
    if (out_w !== 16'hFFFF || ps_w !== 1'b0)
      $display("FAIL after_reset_release: out=%h ps=%b, required ffff 0", out_w, ps_w);
    else passed++;
  endtask

  task automatic test_pwm50();
    int hi0, hi1, bad, nps;
    int pos[$];
    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    do_reset();
    hi0 = 0; hi1 = 0; bad = 0;
    for (int k = 1; k <= 2 * PER + 2; k++) begin
      step();
      if (out_w !== exp_out || ps_w !== exp_ps) bad++;
      if (out_w[15:1] !== 15'h0) bad++;
      if (k <= PER && out_w[0]) hi0++;
      if (k > PER && k <= 2 * PER && out_w[0]) hi1++;
      if (ps_w) pos.push_back(k);
    end
    total++;
    if (bad != 0) $display("FAIL pwm50_model: %0d mismatched cycles, required 0", bad);
    else passed++;
    total++;
    if (hi0 != 1664 || hi1 != 1664)
      $display("FAIL pwm50_high_time: %0d/%0d clk, required 1664", hi0, hi1);
    else passed++;
    nps = pos.size();
    total++;
    if (nps < 3) $display("FAIL pwm50_ps_count: %0d pulses, required 3", nps);
    else if (pos[2] - pos[1] != PER)
      $display("FAIL pwm50_ps_spacing: %0d clk, required %0d", pos[2] - pos[1], PER);
    else passed++;
  endtask

  task automatic test_extremes();
    int bad0, badf;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h00;
    do_reset();
    bad0 = 0; badf = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      if (out_w !== 16'h0000) bad0++;
    end
    duty = 8'hFF;
    for (int k = 0; k < PER; k++) begin
      step();
      if (out_w !== 16'hFFFF) badf++;
    end
    total++;
    if (bad0 != 0) $display("FAIL duty00_const_low: %0d cycles nonzero, required 0", bad0);
    else passed++;
    total++;
    if (badf != 0) $display("FAIL dutyff_const_high: %0d cycles not ffff, required 0", badf);
    else passed++;
  endtask

  task automatic test_split();
    int hi, bad;
    set_en(16'h00FF, 16'hFFFF);
    duty = 8'h40;
    do_reset();
    hi = 0; bad = 0;
    for (int k = 1; k <= PER; k++) begin
      step();
      if (out_w[15:8] !== 8'h00 || out_w !== exp_out) bad++;
      if (out_w[7:0] == 8'hFF) hi++;
      else if (out_w[7:0] !== 8'h00) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL split_pins: %0d bad cycles, required 0", bad);
    else passed++;
    total++;
    if (hi != 832) $display("FAIL split_high_time: %0d clk, required 832", hi);
    else passed++;
  endtask

  task automatic test_duty_change();
    int hi0, hi1;
    set_en(16'h0001, 16'h0001);
    duty = 8'h20;
    do_reset();
    hi0 = 0; hi1 = 0;
    for (int k = 1; k <= 16'h50 * P; k++) begin
      step();
      if (out_w[0]) hi0++;
    end
    total++;
    if (out_w[0] !== 1'b0) $display("FAIL duty_before_write: out0=%b, required 0", out_w[0]);
    else passed++;
    duty = 8'hC0;
    step();
    if (out_w[0]) hi0++;
`ifndef PWM_SYNC_UPDATE_EN
    total++;
    if (out_w[0] !== 1'b1) $display("FAIL duty_live_update: out0=%b, required 1", out_w[0]);
    else passed++;
`else
    total++;
    if (out_w[0] !== 1'b0) $display("FAIL duty_shadow_hold: out0=%b, required 0", out_w[0]);
    else passed++;
    for (int k = 16'h50 * P + 2; k <= PER; k++) begin
      step();
      if (out_w[0]) hi0++;
    end
    for (int k = 1; k <= PER; k++) begin
      step();
      if (out_w[0]) hi1++;
    end
    total++;
    if (hi0 != 416 || hi1 != 2496)
      $display("FAIL duty_shadow_periods: %0d/%0d clk, required 416/2496", hi0, hi1);
    else passed++;
`endif
  endtask

  task automatic test_enable_toggle();
    set_en(16'h000F, 16'h000F);
    duty = 8'h80;
    do_reset();
    for (int k = 1; k <= 16'h10 * P; k++) step();
    set_en(16'h0007, 16'h000F);
    step();
    total++;
    if (out_w[3] !== 1'b0 || out_w[0] !== 1'b1)
      $display("FAIL enable_off: out=%h, required bit3=0 bit0=1", out_w);
    else passed++;
    for (int k = 0; k < 20; k++) step();
    set_en(16'h000F, 16'h000F);
    step();
    total++;
    if (out_w !== 16'h000F) $display("FAIL enable_resume: out=%h, required 000f", out_w);
    else passed++;
    for (int k = 0; k < 16'h70 * P; k++) step();
    total++;
    if (out_w !== 16'h0000 || out_w !== exp_out)
      $display("FAIL enable_in_phase: out=%h, required 0000", out_w);
    else passed++;
  endtask

  task automatic test_random();
    int bad;
    logic [7:0] dsel;
    bad = 0;
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(7) == 0) begin
        set_en(16'($urandom), 16'($urandom));
        dsel = 8'($urandom_range(3));
        duty = (dsel == 0) ? 8'h00 : (dsel == 1) ? 8'hFF : 8'($urandom);
      end
      rst = ($urandom_range(999) == 0);
      step();
      if (out_w !== exp_out || ps_w !== exp_ps) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle %0d: out=%h ps=%b, required out=%h ps=%b",
                   k, out_w, ps_w, exp_out, exp_ps);
      end
    end
    rst = 1'b0;
    total++;
    if (bad == 0) passed++;
  endtask

  initial begin
    rst = 1'b1;
    set_en(16'h0000, 16'h0000);
    duty = 8'h00;
    n = 0;
    m_shadow = 8'h00;
    test_reset();
    test_pwm50();
    test_extremes();
    test_split();
    test_duty_change();
    test_enable_toggle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register bank.
- Takes the five 8-bit control registers: output-enable low/high, PWM-enable low/high and duty cycle.
- Drives 16 output pins, each forced low, held static high, or PWM-modulated at a fixed frequency of about 3 kHz.
- Runs in the system clock domain; the SPI register outputs arrive already synchronised to clk.

Parameters:
- PRESCALE, 13, system-clock cycles per PWM counter tick (10 MHz / 13 / 256 ≈ 3.0 kHz PWM period); legal range 1..65535.
- PRESCALE_W, 16, width of the prescaler counter; must hold PRESCALE-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en_reg_out_7_0  input  8  output enable, pins 7..0 (SPI addr 0x00).
- en_reg_out_15_8  input  8  output enable, pins 15..8 (SPI addr 0x01).
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0 (SPI addr 0x02).
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8 (SPI addr 0x03).
- pwm_duty_cycle  input  8  shared duty cycle, 0x00..0xFF (SPI addr 0x04).
- out  output  16  pin drive; out[15:8] uses the *_15_8 inputs, out[7:0] uses the *_7_0 inputs.
- period_start  output  1  single-cycle pulse at the start of each PWM period.

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler, pwm_cnt, duty shadow, out and period_start all go to 0.
  - Reset takes priority over every other event, including mid-period; the next period starts cleanly from pwm_cnt=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted in the cycle the prescaler equals PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- pwm_cnt:
  - 8-bit; increments on tick and wraps 255 -> 0.
  - Holds its value between ticks.
  - One PWM period = 256*PRESCALE clk cycles.
- period_start:
  - Registered; high for exactly 1 clk in the cycle after the tick that wraps pwm_cnt 255 -> 0.
  - Also high for 1 clk in the first cycle after reset is released.
- Effective duty d: taken from the duty source defined under Optional Feature.
- pwm_sig (combinational):
  - d == 0xFF -> 1 (100% duty, special case).
  - otherwise pwm_sig = (pwm_cnt < d).
  - d == 0x00 -> always 0.
  - High time of d/256 of the period for d in 0x01..0xFE.
- Per-pin output, registered, with 1 clk latency from inputs/counter to out:
  - en_out[i]=0 -> out[i]=0, regardless of PWM enable.
  - en_out[i]=1, en_pwm[i]=0 -> out[i]=1.
  - en_out[i]=1, en_pwm[i]=1 -> out[i]=pwm_sig.
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm is concatenated the same way.
- All 16 PWM pins share one counter, so they are phase-aligned.
- Enable inputs are never shadowed: an enable change is visible on out exactly 1 clk later, even mid-period.
- Boundary conditions:
  - Duty changes in the same cycle as a wrap tick are captured as the new period's duty (shadow mode).
  - pwm_cnt wrap and prescaler wrap coincide by construction; there is no separate boundary state.

Optional Feature:
- Macro: PWM_SYNC_UPDATE_EN.
- Defined:
  - pwm_duty_cycle is copied into an 8-bit shadow register only on the cycle where tick is high and pwm_cnt==255, or during reset release, where shadow = input.
  - d = shadow, so a period is never glitched by a mid-period duty write.
  - The first period after reset uses the duty present in the first post-reset cycle.
- Undefined:
  - No shadow register; d = pwm_duty_cycle directly.
  - A duty change affects out 1 clk later, possibly producing one truncated or stretched pulse in that period.

Test Plan:
- Reset, then en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF one clk after inputs settle; assert rst for 1 clk -> out=0x0000 the next cycle, counters at 0.
- en_out=0x0001, en_pwm=0x0001, duty=0x80, PRESCALE=13 -> out[0] high for 128*13=1664 clk and low for 1664 clk; period 3328 clk; period_start spacing 3328; out[15:1]=0.
- duty=0x00 then 0xFF with en_out=en_pwm=0xFFFF -> out constant 0x0000 for a full period, then constant 0xFFFF for a full period (no single-tick low pulse at 0xFF).
- en_out=0x00FF, en_pwm=0xFFFF, duty=0x40 -> out[7:0] PWM at 25% (832 clk high per period), out[15:8]=0 throughout.
- With PWM_SYNC_UPDATE_EN: duty 0x20 -> 0xC0 written at pwm_cnt=0x50 -> current period keeps 0x20 high time (416 clk), next period high 2496 clk. Without the macro: out goes high again 1 clk after the write, at pwm_cnt 0x50.
- Enable toggled mid-period (en_out[3] 1->0 at pwm_cnt=0x10, duty=0x80) -> out[3]=0 exactly 1 clk later; re-enabling resumes in phase with the shared counter.
